muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative, parametrised successor to the combinational multiply/divide extension. It executes all eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles, using one shift/add-subtract datapath, under a start/busy/done handshake. The block sits beside the ALU in the CPU: the decoder issues `start` and stalls the PC while `busy` is high, and `MDOut` feeds the register write-back mux.

## Interface
- `DWIDTH`, 32: operand and result width; even; ≥ 8.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  request; sampled only when `busy` = 0.
- `abort`  in  1  pipeline flush; cancels an in-flight operation.
- `MDFunc`  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`  in  DWIDTH  rs1 operand (multiplicand / dividend).
- `B`  in  DWIDTH  rs2 operand (multiplier / divisor).
- `busy`  out  1  operation in progress; new `start` is ignored.
- `done`  out  1  one-cycle pulse; `MDOut` is valid from this cycle on.
- `MDOut`  out  DWIDTH  result; held until the next accepted operation completes.

## Operation
- States: IDLE, CALC, FIX, DONE. After reset the state is IDLE, with `busy` = 0, `done` = 0, `MDOut` = 0, and the internal registers zeroed.
- Accept: in IDLE or DONE, `start` = 1 and `abort` = 0 latch `A`, `B`, and `MDFunc`. The latched values are used for the whole operation, and input changes afterwards have no effect.
- Signedness: A is signed for MULH, MULHSU, DIV and REM. B is signed for MULH, DIV and REM. Signed operands are converted to magnitudes at accept, and the result sign is recorded.
- Multiply: unsigned shift-add over a 2·DWIDTH product register, one multiplier bit per CALC cycle.
  - FIX negates the 2·DWIDTH product when the result sign is negative.
  - MUL returns product[DWIDTH-1:0]. MULH, MULHSU and MULHU return product[2·DWIDTH-1:DWIDTH].
- Divide: restoring division, one quotient bit per CALC cycle, with a DWIDTH+1-bit partial remainder.
  - FIX negates the quotient when the operand signs differ (DIV only).
  - FIX gives the remainder the sign of the dividend (REM only).
- Special cases skip CALC and FIX and go straight from accept to DONE:
  - Divide by zero: quotient = all ones, remainder = A.
  - Signed overflow (A = 1 followed by DWIDTH-1 zeros, B = all ones; DIV/REM only): quotient = A, remainder = 0.
- Transitions:
  - IDLE → CALC on accept, or IDLE → DONE for a special case.
  - CALC runs exactly DWIDTH cycles, counted by a $clog2(DWIDTH+1)-bit counter, then moves to FIX.
  - FIX → DONE, writing `MDOut`.
  - DONE → IDLE, or DONE → CALC/DONE on a back-to-back accept.
- `busy` = 1 in CALC and FIX only. `done` = 1 in DONE only.
- Abort: `abort` = 1 in CALC or FIX returns the state to IDLE at the next edge. In that case there is no `done` pulse, `MDOut` is unchanged, and `start` in the same cycle is ignored. `abort` in IDLE or DONE blocks acceptance that cycle.

## Timing
- Normal latency: `start` sampled at edge 0; CALC covers edges 1..DWIDTH; FIX at edge DWIDTH+1. `done` is high for the one cycle after edge DWIDTH+1, which is DWIDTH+2 cycles after the start cycle (34 for DWIDTH = 32).
- Special-case latency: `done` is high in the cycle right after edge 0 (1 cycle).
- Throughput: a `start` during the DONE cycle is accepted, giving back-to-back issue with no idle gap.
- `busy` rises in the cycle after edge 0 and falls in the `done` cycle. It stays 0 for special cases.
- Reset asserted mid-operation: all outputs go to their reset values immediately, and the operation is lost. After deassertion the block is in IDLE.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- MUL A = 7, B = 0xFFFFFFFD → `MDOut` 0xFFFFFFEB; `done` exactly 34 cycles after `start`; `busy` high for 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU with the same operands → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM with the same operands → 0. In all four, `done` is 1 cycle after `start` and `busy` never rises.
- Abort and restart:
  - Start DIVU 1000 / 3, then assert `abort` at CALC cycle 10 → no `done`, `busy` low next cycle, `MDOut` retains its previous value.
  - Next start MUL 6 × 7 → 42.
  - Issue a `start` during a DONE cycle → accepted back-to-back.
- Reset and stability:
  - Drive `reset` low mid-CALC → `busy`, `done` and `MDOut` are 0 immediately.
  - After release, REMU 17 / 5 → 2.
  - Change `A`, `B` and `MDFunc` during CALC → result unaffected.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shift/add-subtract step per cycle.
// The start/busy/done handshake lets the decoder stall while an operation runs.
module muldiv_seq #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        MDFunc,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] MDOut
);

  localparam int unsigned W  = DWIDTH;
  localparam int unsigned CW = $clog2(DWIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [2*W-1:0]  prod, prod_nxt;
  logic [W-1:0]    rem, rem_nxt;
  logic [W-1:0]    opnd, opnd_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      func, func_nxt;
  logic            neg, neg_nxt;
  logic            busy_nxt, done_nxt;
  logic [W-1:0]    out_nxt;

  // Operand conditioning at accept: signedness, magnitudes and special cases
  logic         sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf, special, accept;
  logic [W-1:0] mag_a, mag_b, special_res;

  assign sgn_a    = (MDFunc == 3'b001) || (MDFunc == 3'b010) ||
                    (MDFunc == 3'b100) || (MDFunc == 3'b110);
  assign sgn_b    = (MDFunc == 3'b001) || (MDFunc == 3'b100) || (MDFunc == 3'b110);
  assign neg_a    = sgn_a & A[W-1];
  assign neg_b    = sgn_b & B[W-1];
  assign mag_a    = neg_a ? W'(-A) : A;
  assign mag_b    = neg_b ? W'(-B) : B;
  assign div_zero = MDFunc[2] & (B == '0);
  assign div_ovf  = MDFunc[2] & ~MDFunc[0] & (A == {1'b1, {(W-1){1'b0}}}) & (&B);
  assign special  = div_zero | div_ovf;
  // Remainder ops return A (div by zero) or 0 (overflow); quotient ops all-ones or A
  assign special_res = MDFunc[1] ? (div_zero ? A : '0) : (div_zero ? '1 : A);
  assign accept   = start & ~abort & ((state == IDLE) || (state == DONE));

  // One iteration: shift-add multiply step and restoring divide step
  logic [W:0] mul_sum, div_sh, div_diff;

  assign mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : (W+1)'(0));
  assign div_sh   = {rem, prod[W-1]};
  assign div_diff = div_sh - {1'b0, opnd};

  // Sign fix-up and result selection
  logic [2*W-1:0] prod_sgn;
  logic [W-1:0]   quo_sgn, rem_sgn, fix_res;

  assign prod_sgn = neg ? (2*W)'(-prod) : prod;
  assign quo_sgn  = neg ? W'(-prod[W-1:0]) : prod[W-1:0];
  assign rem_sgn  = neg ? W'(-rem) : rem;

  always_comb begin
    fix_res = quo_sgn;
    case (func)
      3'b000:                 fix_res = prod_sgn[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_sgn[2*W-1:W];
      3'b110, 3'b111:         fix_res = rem_sgn;
      default:                fix_res = quo_sgn;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    prod_nxt  = prod;
    rem_nxt   = rem;
    opnd_nxt  = opnd;
    cnt_nxt   = cnt;
    func_nxt  = func;
    neg_nxt   = neg;
    out_nxt   = MDOut;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          func_nxt  = MDFunc;
          neg_nxt   = (MDFunc[2] & MDFunc[1]) ? neg_a : (neg_a ^ neg_b);
          opnd_nxt  = MDFunc[2] ? mag_b : mag_a;
          prod_nxt  = {{W{1'b0}}, (MDFunc[2] ? mag_a : mag_b)};
          rem_nxt   = '0;
          cnt_nxt   = '0;
          if (special) begin
            out_nxt   = special_res;
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          if (!func[2]) begin
            prod_nxt = {mul_sum, prod[W-1:1]};
          end else if (!div_diff[W]) begin
            rem_nxt  = div_diff[W-1:0];
            prod_nxt = {prod[2*W-1:W], prod[W-2:0], 1'b1};
          end else begin
            rem_nxt  = div_sh[W-1:0];
            prod_nxt = {prod[2*W-1:W], prod[W-2:0], 1'b0};
          end
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(W - 1)) state_nxt = FIX;
        end
      end
      FIX: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          out_nxt   = fix_res;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == CALC) || (state_nxt == FIX);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      prod  <= '0;
      rem   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      func  <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      MDOut <= '0;
    end else begin
      state <= state_nxt;
      prod  <= prod_nxt;
      rem   <= rem_nxt;
      opnd  <= opnd_nxt;
      cnt   <= cnt_nxt;
      func  <= func_nxt;
      neg   <= neg_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      MDOut <= out_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clock, reset, start, abort;
  logic [2:0]  MDFunc;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] MDOut;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_res;

  muldiv_seq #(.DWIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .MDFunc(MDFunc), .A(A), .B(B),
    .busy(busy), .done(done), .MDOut(MDOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    logic ovf;
    ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = ea * eb;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue an operation at a negedge; returns at the negedge after the accept edge
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; MDFunc = f; A = a; B = b;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    A      = $urandom;
    B      = $urandom;
    MDFunc = 3'($urandom_range(0, 7));
  endtask

  task automatic finish_op(output logic [31:0] res, output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      bcnt += int'(busy);
      @(negedge clock);
      lat++;
    end
    check("done_seen", 64'(done), 64'd1);
    res = MDOut;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] res;
    int lat, bc;
    bit sp;
    sp = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    launch(f, a, b);
    finish_op(res, lat, bc);
    last_res = ref_md(f, a, b);
    check({tag, "/res"}, 64'(res), 64'(last_res));
    check({tag, "/lat"}, 64'(lat), sp ? 64'd1 : 64'd34);
    check({tag, "/busy"}, 64'(bc), sp ? 64'd0 : 64'd33);
  endtask

  initial begin
    int dcnt;
    logic [2:0]  f;
    logic [31:0] a, b;
    clock = 0; reset = 0; start = 0; abort = 0; MDFunc = 0; A = 0; B = 0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out", 64'(MDOut), 64'd0);
    reset = 1;
    @(negedge clock);

    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    do_op("divu_by0", 3'd5, 32'd5, 32'd0);
    do_op("remu_by0", 3'd7, 32'd5, 32'd0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div_by0", 3'd4, 32'hFFFF_FFF0, 32'd0);
    do_op("rem_by0", 3'd6, 32'hFFFF_FFF0, 32'd0);

    // Abort at CALC cycle 10: no done, busy drops, result held
    launch(3'd5, 32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out", 64'(MDOut), 64'(last_res));
    dcnt = 0;
    repeat (40) begin
      @(negedge clock);
      dcnt += int'(done) + int'(busy);
    end
    check("abort_quiet", 64'(dcnt), 64'd0);

    // Abort in IDLE blocks acceptance
    start = 1'b1; abort = 1'b1; MDFunc = 3'd0; A = 32'd3; B = 32'd3;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'd0);
    check("idle_abort_done", 64'(done), 64'd0);

    do_op("mul_6_7", 3'd0, 32'd6, 32'd7);
    do_op("b2b_divu", 3'd5, 32'd100, 32'd7);
    do_op("b2b_spec", 3'd7, 32'd9, 32'd0);
    do_op("b2b_after", 3'd1, 32'hFFFF_FFFE, 32'd3);

    // Asynchronous reset mid-CALC
    launch(3'd0, 32'd12345, 32'd678);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_out", 64'(MDOut), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("arst_idle", 64'(busy), 64'd0);
    do_op("remu_17_5", 3'd7, 32'd17, 32'd5);

    // Randomized operations with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clock);
        check("done_pulse", 64'(done), 64'd0);
      end
      do_op("rand", f, a, b);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
